// File: rtl/astar_insert_scheduler.sv
// Serialises a four-neighbour batch of scored packets into open-list queue writes
// and arbitrates the single-port queue between those inserts and expansion pops.
module astar_insert_scheduler #(
  parameter int DATA_WIDTH  = 24,
  parameter int STALL_LIMIT = 16,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   batch_valid,
  output logic                   batch_ready,
  input  logic [DATA_WIDTH-1:0]  packet_N_in,
  input  logic [DATA_WIDTH-1:0]  packet_E_in,
  input  logic [DATA_WIDTH-1:0]  packet_S_in,
  input  logic [DATA_WIDTH-1:0]  packet_W_in,
  output logic                   q_wr_en,
  output logic [DATA_WIDTH-1:0]  q_wr_data,
  input  logic                   q_full,
  output logic                   q_rd_en,
  input  logic                   q_rd_valid,
  input  logic [DATA_WIDTH-1:0]  q_rd_data,
  input  logic                   q_empty,
  input  logic                   pop_req,
  output logic                   pop_valid,
  output logic [DATA_WIDTH-1:0]  pop_data,
  output logic                   pop_empty,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] insert_count,
  output logic [COUNT_WIDTH-1:0] drop_count
);

  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);

  typedef enum logic [1:0] {IDLE, DRAIN, POP_WAIT} state_t;

  state_t                 state_reg, state_next;
  logic [3:0]             pending_reg, pending_next;
  logic [SW-1:0]          stall_reg, stall_next, stall_inc;
  logic [DATA_WIDTH-1:0]  pkt_reg [4];
  logic [DATA_WIDTH-1:0]  pkt_in [4];
  logic [3:0]             in_valid;
  logic [3:0]             lowest;
  logic [2:0]             pend_cnt;
  logic [COUNT_WIDTH:0]   drop_sum;
  logic                   load_batch;
  logic                   pop_accept;
  logic                   pop_valid_reg, pop_valid_next;
  logic                   pop_empty_reg, pop_empty_next;
  logic [DATA_WIDTH-1:0]  pop_data_reg, pop_data_next;
  logic [DATA_WIDTH-1:0]  wr_mux;
  logic [COUNT_WIDTH-1:0] insert_count_reg, insert_count_next;
  logic [COUNT_WIDTH-1:0] drop_count_reg, drop_count_next;

  // Index order N, E, S, W doubles as the service priority.
  assign pkt_in[0] = packet_N_in;
  assign pkt_in[1] = packet_E_in;
  assign pkt_in[2] = packet_S_in;
  assign pkt_in[3] = packet_W_in;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pkt
      assign in_valid[gi] = ~pkt_in[gi][0];
      always_ff @(posedge clk) begin
        if (rst)
          pkt_reg[gi] <= '0;
        else if (load_batch)
          pkt_reg[gi] <= pkt_in[gi];
      end
    end
  endgenerate

  assign lowest    = pending_reg & (~pending_reg + 4'd1);
  assign stall_inc = stall_reg + 1'b1;

  always_comb begin
    wr_mux   = '0;
    pend_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      wr_mux   = wr_mux | ({DATA_WIDTH{lowest[i]}} & pkt_reg[i]);
      pend_cnt = pend_cnt + {2'b00, pending_reg[i]};
    end
  end

  assign drop_sum = {1'b0, drop_count_reg} + {{(COUNT_WIDTH-2){1'b0}}, pend_cnt};

  // A pop is taken only when no batch competes and no completion is still on the output.
  assign pop_accept  = (state_reg == IDLE) && pop_req && !batch_valid && !pop_valid_reg;
  assign q_rd_en     = pop_accept && !q_empty;
  assign q_wr_en     = (state_reg == DRAIN) && (pending_reg != 4'd0) && !q_full;
  assign q_wr_data   = wr_mux;
  assign batch_ready = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);

  always_comb begin
    state_next        = state_reg;
    pending_next      = pending_reg;
    stall_next        = stall_reg;
    load_batch        = 1'b0;
    pop_valid_next    = 1'b0;
    pop_empty_next    = 1'b0;
    pop_data_next     = pop_data_reg;
    insert_count_next = insert_count_reg;
    drop_count_next   = drop_count_reg;
    case (state_reg)
      IDLE: begin
        if (batch_valid) begin
          load_batch   = 1'b1;
          pending_next = in_valid;
          stall_next   = '0;
          if (in_valid != 4'd0)
            state_next = DRAIN;
        end else if (pop_accept) begin
          if (q_empty) begin
            pop_valid_next = 1'b1;
            pop_empty_next = 1'b1;
            pop_data_next  = '0;
          end else begin
            state_next = POP_WAIT;
          end
        end
      end
      DRAIN: begin
        if (pending_reg == 4'd0) begin
          state_next = IDLE;
        end else if (q_wr_en) begin
          pending_next = pending_reg & ~lowest;
          stall_next   = '0;
          if (insert_count_reg != '1)
            insert_count_next = insert_count_reg + 1'b1;
          if ((pending_reg & ~lowest) == 4'd0)
            state_next = IDLE;
        end else if (stall_inc == STALL_MAX) begin
          drop_count_next = drop_sum[COUNT_WIDTH] ? '1 : drop_sum[COUNT_WIDTH-1:0];
          pending_next    = 4'd0;
          stall_next      = '0;
          state_next      = IDLE;
        end else begin
          stall_next = stall_inc;
        end
      end
      POP_WAIT: begin
        if (q_rd_valid) begin
          pop_valid_next = 1'b1;
          pop_data_next  = q_rd_data;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      pending_reg      <= 4'd0;
      stall_reg        <= '0;
      pop_valid_reg    <= 1'b0;
      pop_empty_reg    <= 1'b0;
      pop_data_reg     <= '0;
      insert_count_reg <= '0;
      drop_count_reg   <= '0;
    end else begin
      state_reg        <= state_next;
      pending_reg      <= pending_next;
      stall_reg        <= stall_next;
      pop_valid_reg    <= pop_valid_next;
      pop_empty_reg    <= pop_empty_next;
      pop_data_reg     <= pop_data_next;
      insert_count_reg <= insert_count_next;
      drop_count_reg   <= drop_count_next;
    end
  end

  assign pop_valid    = pop_valid_reg;
  assign pop_empty    = pop_empty_reg;
  assign pop_data     = pop_data_reg;
  assign insert_count = insert_count_reg;
  assign drop_count   = drop_count_reg;

endmodule

// File: tb/tb_astar_insert_scheduler.sv
// Randomised and directed checks of astar_insert_scheduler against a queue-based
// model of expected queue writes, pops and statistics.
module tb_astar_insert_scheduler;
  localparam int DW = 24;
  localparam int SL = 16;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          batch_valid, batch_ready;
  logic [DW-1:0] packet_N_in, packet_E_in, packet_S_in, packet_W_in;
  logic          q_wr_en;
  logic [DW-1:0] q_wr_data;
  logic          q_full, q_rd_en, q_rd_valid, q_empty;
  logic [DW-1:0] q_rd_data;
  logic          pop_req, pop_valid, pop_empty, busy;
  logic [DW-1:0] pop_data;
  logic [CW-1:0] insert_count, drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  int m_ins    = 0;
  int m_drop   = 0;

  astar_insert_scheduler #(.DATA_WIDTH(DW), .STALL_LIMIT(SL), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .batch_valid(batch_valid), .batch_ready(batch_ready),
    .packet_N_in(packet_N_in), .packet_E_in(packet_E_in),
    .packet_S_in(packet_S_in), .packet_W_in(packet_W_in),
    .q_wr_en(q_wr_en), .q_wr_data(q_wr_data), .q_full(q_full),
    .q_rd_en(q_rd_en), .q_rd_valid(q_rd_valid), .q_rd_data(q_rd_data), .q_empty(q_empty),
    .pop_req(pop_req), .pop_valid(pop_valid), .pop_data(pop_data), .pop_empty(pop_empty),
    .busy(busy), .insert_count(insert_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic logic [DW-1:0] rnd_pkt(input int inval_pct);
    logic [DW-1:0] v;
    v    = DW'($urandom);
    v[0] = ($urandom_range(99) < inval_pct);
    return v;
  endfunction

  // mode: 0 never full, 1 random full, 2 full for 3 cycles after the first write, 3 always full
  task automatic run_batch(input logic [DW-1:0] n, input logic [DW-1:0] e,
                           input logic [DW-1:0] s, input logic [DW-1:0] w, input int mode);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pk[4];
    int consec, cyc, wr_done, hold, k;
    logic full;
    pk[0] = n; pk[1] = e; pk[2] = s; pk[3] = w;
    for (int i = 0; i < 4; i++) if (!pk[i][0]) exp_q.push_back(pk[i]);
    k = exp_q.size();
    packet_N_in = n; packet_E_in = e; packet_S_in = s; packet_W_in = w;
    batch_valid = 1'b1; q_full = 1'b0;
    @(negedge clk);
    check_eq("accept_ready", 32'(batch_ready), 32'd1);
    check_eq("accept_no_wr", 32'(q_wr_en), 32'd0);
    check_eq("accept_no_rd", 32'(q_rd_en), 32'd0);
    tick();
    batch_valid = 1'b0;
    packet_N_in = rnd_pkt(50); packet_E_in = rnd_pkt(50);
    packet_S_in = rnd_pkt(50); packet_W_in = rnd_pkt(50);
    consec = 0; cyc = 0; wr_done = 0; hold = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      case (mode)
        1: full = ($urandom_range(99) < 30);
        2: full = (wr_done == 1 && hold < 3);
        3: full = 1'b1;
        default: full = 1'b0;
      endcase
      if (full && mode == 2) hold++;
      q_full = full;
      @(negedge clk);
      check_eq("drain_wr_en", 32'(q_wr_en), 32'(!full));
      check_eq("drain_busy", 32'(busy), 32'd1);
      check_eq("drain_not_ready", 32'(batch_ready), 32'd0);
      check_eq("drain_no_rd", 32'(q_rd_en), 32'd0);
      if (!full) begin
        check_eq("drain_wr_data", 32'(q_wr_data), 32'(exp_q.pop_front()));
        m_ins   = sat(m_ins + 1);
        consec  = 0;
        wr_done++;
      end else begin
        consec++;
        if (consec == SL) begin
          m_drop = sat(m_drop + exp_q.size());
          exp_q.delete();
        end
      end
      tick();
      cyc++;
    end
    if (cyc >= 200) check_eq("drain_timeout", 32'(cyc), 32'd0);
    q_full = 1'b0;
    @(negedge clk);
    check_eq("done_ready", 32'(batch_ready), 32'd1);
    check_eq("done_busy", 32'(busy), 32'd0);
    check_eq("done_no_wr", 32'(q_wr_en), 32'd0);
    check_eq("done_rd_en", 32'(q_rd_en), 32'(pop_req && !q_empty));
    check_eq("insert_count", 32'(insert_count), 32'(m_ins));
    check_eq("drop_count", 32'(drop_count), 32'(m_drop));
    $display("batch k=%0d mode=%0d cycles=%0d ins=%0d drop=%0d", k, mode, cyc, m_ins, m_drop);
    tick();
  endtask

  // Continues a non-empty pop: called on the cycle after q_rd_en was seen.
  task automatic pop_wait(input int delay, input logic [DW-1:0] data);
    for (int c = 1; c <= delay; c++) begin
      q_rd_valid = (c == delay);
      q_rd_data  = (c == delay) ? data : DW'($urandom);
      @(negedge clk);
      check_eq("wait_no_pop", 32'(pop_valid), 32'd0);
      check_eq("wait_no_rd", 32'(q_rd_en), 32'd0);
      check_eq("wait_busy", 32'(busy), 32'd1);
      tick();
    end
    q_rd_valid = 1'b0;
    @(negedge clk);
    check_eq("pop_valid", 32'(pop_valid), 32'd1);
    check_eq("pop_data", 32'(pop_data), 32'(data));
    check_eq("pop_empty", 32'(pop_empty), 32'd0);
    check_eq("pop_no_rd", 32'(q_rd_en), 32'd0);
    check_eq("pop_idle", 32'(busy), 32'd0);
    tick();
    pop_req = 1'b0;
    @(negedge clk);
    check_eq("pop_once", 32'(pop_valid), 32'd0);
    $display("pop delay=%0d data=%h", delay, data);
    tick();
  endtask

  task automatic do_pop(input logic empty, input int delay, input logic [DW-1:0] data);
    pop_req = 1'b1; q_empty = empty;
    @(negedge clk);
    check_eq("req_rd_en", 32'(q_rd_en), 32'(!empty));
    check_eq("req_no_pop", 32'(pop_valid), 32'd0);
    tick();
    q_empty = 1'b0;
    if (empty) begin
      @(negedge clk);
      check_eq("empty_pop_valid", 32'(pop_valid), 32'd1);
      check_eq("empty_pop_empty", 32'(pop_empty), 32'd1);
      check_eq("empty_pop_data", 32'(pop_data), 32'd0);
      check_eq("empty_no_rd", 32'(q_rd_en), 32'd0);
      tick();
      pop_req = 1'b0;
      @(negedge clk);
      check_eq("empty_pop_once", 32'(pop_valid), 32'd0);
      $display("pop empty");
      tick();
    end else begin
      pop_wait(delay, data);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; batch_valid = 1'b0; q_full = 1'b0; q_rd_valid = 1'b0; q_empty = 1'b1;
    pop_req = 1'b0; q_rd_data = '0;
    packet_N_in = '0; packet_E_in = '0; packet_S_in = '0; packet_W_in = '0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", 32'(batch_ready), 32'd1);
    check_eq("rst_wr_en", 32'(q_wr_en), 32'd0);
    check_eq("rst_rd_en", 32'(q_rd_en), 32'd0);
    check_eq("rst_pop_valid", 32'(pop_valid), 32'd0);
    check_eq("rst_pop_empty", 32'(pop_empty), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_pop_data", 32'(pop_data), 32'd0);
    check_eq("rst_wr_data", 32'(q_wr_data), 32'd0);
    check_eq("rst_insert", 32'(insert_count), 32'd0);
    check_eq("rst_drop", 32'(drop_count), 32'd0);
    tick();

    run_batch(24'h9A1230, 24'h5B4561, 24'h7C7890, 24'h1D0002, 0);
    run_batch(24'h000001, 24'h111111, 24'h222223, 24'hFFFFFF, 0);
    run_batch(24'hA00000, 24'hB00000, 24'hC00000, 24'hD00000, 2);
    run_batch(24'h123456, 24'h234560, 24'h345678, 24'h456780, 3);

    pop_req = 1'b1; q_empty = 1'b0;
    run_batch(24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C, 24'h0D0D0C, 0);
    pop_wait(2, 24'h345670);
    do_pop(1'b1, 0, '0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(2) != 0)
        run_batch(rnd_pkt(35), rnd_pkt(35), rnd_pkt(35), rnd_pkt(35), $urandom_range(1));
      else
        do_pop($urandom_range(3) == 0, $urandom_range(4, 1), DW'($urandom));
    end

    // Enough fully valid batches to push insert_count past its ceiling.
    for (int it = 0; it < 64; it++)
      run_batch(rnd_pkt(0), rnd_pkt(0), rnd_pkt(0), rnd_pkt(0), 0);

    packet_N_in = 24'h111110; packet_E_in = 24'h222220;
    packet_S_in = 24'h333330; packet_W_in = 24'h444440;
    batch_valid = 1'b1;
    tick();
    batch_valid = 1'b0;
    @(negedge clk);
    check_eq("rstmid_wr_en", 32'(q_wr_en), 32'd1);
    check_eq("rstmid_wr_data", 32'(q_wr_data), 32'h111110);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ins = 0; m_drop = 0;
    q_rd_valid = 1'b1; q_rd_data = 24'hBADBAD;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("rstmid_idle", 32'(busy), 32'd0);
      check_eq("rstmid_no_wr", 32'(q_wr_en), 32'd0);
      check_eq("rstmid_no_pop", 32'(pop_valid), 32'd0);
      check_eq("rstmid_insert", 32'(insert_count), 32'(m_ins));
      check_eq("rstmid_drop", 32'(drop_count), 32'(m_drop));
      tick();
      q_rd_valid = 1'b0;
    end
    $display("reset mid-drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/astar_insert_scheduler.md
# astar_insert_scheduler

Sequencer between the neighbour-scoring stage and the single-port open-list priority queue of the A* search engine. It accepts one batch of four scored neighbour packets (N, E, S, W) per expansion, discards invalid ones and serialises the rest into queue writes. It also arbitrates the queue between those inserts and pop requests from the expansion controller, and keeps insert and drop statistics.

## Interface
- DATA_WIDTH, 24, packet width (cell col/row + score fields + bit 0 invalid flag)
- STALL_LIMIT, 16, consecutive q_full cycles tolerated in DRAIN before the remaining entries are dropped
- COUNT_WIDTH, 8, width of the statistics counters
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- batch_valid  in  1  four packets presented (driven by scoring stage write_en)
- batch_ready  out  1  scheduler can accept a batch
- packet_N_in, packet_E_in, packet_S_in, packet_W_in  in  DATA_WIDTH each  scored packets; bit 0 = 1 means invalid
- q_wr_en  out  1  queue insert strobe
- q_wr_data  out  DATA_WIDTH  packet being inserted
- q_full  in  1  queue cannot accept a write this cycle
- q_rd_en  out  1  queue pop strobe (1-cycle pulse)
- q_rd_valid  in  1  queue returns popped data
- q_rd_data  in  DATA_WIDTH  popped packet
- q_empty  in  1  queue empty
- pop_req  in  1  expansion controller requests the best entry; held until pop_valid
- pop_valid  out  1  1-cycle pulse that completes a pop
- pop_data  out  DATA_WIDTH  popped packet, valid with pop_valid
- pop_empty  out  1  with pop_valid: queue was empty and pop_data is 0
- busy  out  1  state != IDLE
- insert_count, drop_count  out  COUNT_WIDTH each  saturating totals of written and dropped valid packets

## Operation
- States: IDLE, DRAIN, POP_WAIT.
- IDLE:
  - batch_ready=1.
  - On batch_valid, register the four packets and pending[3:0] = {~W[0], ~S[0], ~E[0], ~N[0]}.
  - If pending != 0, go to DRAIN; otherwise stay in IDLE and write nothing.
- Priority: batch_valid beats pop_req in the same IDLE cycle. The pop is serviced on a later IDLE cycle with no batch_valid.
- DRAIN:
  - batch_ready=0.
  - Service order is N, E, S, W, lowest set pending bit first.
  - q_wr_en = (pending != 0) && !q_full, combinational from registered state and q_full.
  - q_wr_data = the registered packet selected by the lowest set pending bit.
  - On a write, clear that bit and increment insert_count.
  - After the last write, go to IDLE.
  - Stall counter: increments on each DRAIN cycle with q_full=1 and clears on any write. When it reaches STALL_LIMIT, add popcount(pending) to drop_count, clear pending and go to IDLE. No write occurs in that cycle.
- Pop from IDLE with pop_req and no batch_valid:
  - If q_empty: next cycle pop_valid=1, pop_empty=1, pop_data=0. No q_rd_en. Stay in IDLE.
  - Else: q_rd_en=1 for exactly that cycle, then go to POP_WAIT.
- POP_WAIT:
  - Wait for q_rd_valid, with no timeout.
  - On q_rd_valid, next cycle pop_valid=1, pop_data=q_rd_data, pop_empty=0, and return to IDLE.
  - batch_valid is ignored in POP_WAIT (batch_ready=0).
- Counters saturate at 2^COUNT_WIDTH-1.
- drop_count counts only valid packets lost to a stall, never invalid-flagged packets.

## Timing
- Reset values:
  - state=IDLE, pending=0, stall counter=0.
  - batch_ready=1. q_wr_en=0, q_rd_en=0, pop_valid=0, pop_empty=0, busy=0.
  - pop_data=0, q_wr_data=0, insert_count=0, drop_count=0.
- Reset mid-DRAIN or mid-POP_WAIT discards pending packets and the outstanding pop without counting them. A q_rd_valid arriving after reset is ignored.
- Batch accepted at cycle t with k valid packets and no q_full:
  - writes occur at t+1..t+k;
  - batch_ready=1 again at t+k+1 (k=0: batch_ready stays 1 at t+1).
- Each q_full cycle delays the remaining writes by one cycle.
- Pop on non-empty queue: q_rd_en at cycle t. If q_rd_valid arrives at t+d, pop_valid is at t+d+1.
- Pop on empty queue: pop_req at t, pop_valid at t+1.
- pop_valid, q_rd_en and q_wr_en are never high for a stale request. At most one of q_wr_en or q_rd_en is high in any cycle.

## Test plan
- Reset check: after rst, all outputs at their reset values. Then N=24'h9A1230, E=24'h5B4561, S=24'h7C7890, W=24'h1D0002 with batch_valid for one cycle → writes of 24'h9A1230, 24'h7C7890, 24'h1D0002 on three consecutive cycles; E is skipped. insert_count=3 and batch_ready returns 4 cycles after acceptance.
- All four bit0=1 → no q_wr_en, state stays IDLE, insert_count unchanged, batch_ready=1 on the next cycle.
- Back-pressure: four valid packets with q_full held high for 3 cycles after the first write → writes resume in order with no loss; insert_count=4.
- Stall drop: four valid packets with q_full high forever, STALL_LIMIT=16 → zero writes; after 16 DRAIN cycles drop_count=4, state=IDLE, busy=0.
- Simultaneous batch_valid and pop_req in IDLE → batch drains first, then q_rd_en pulses once. q_rd_valid 2 cycles later with 24'h345670 → pop_valid with pop_data=24'h345670, pop_empty=0. Separately, pop_req with q_empty=1 → pop_valid next cycle, pop_empty=1, pop_data=0, no q_rd_en.
- Reset asserted mid-DRAIN after 1 of 4 writes → next cycle IDLE, no further writes, insert_count=0, drop_count=0.
